encoder_seq: RTL

ENCODER_SEQ -- requirements
Module: encoder_seq

---
 rtl/encoder_pkg.sv | 20 ++
 rtl/encoder_seq_if.sv | 39 +++
 rtl/raster_counter.sv | 48 ++++
 rtl/encoder_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared types and default dimensions for the encoder sequencer
// Purpose: sequencer state enum, default image geometry and trace watchdog limit.
// Ports: none (package).
package encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_SEED  = 3'd3,
    ST_TRACE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int IMG_W_DEF   = 16;
  localparam int IMG_H_DEF   = 16;
  localparam int ADDR_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 1023;

endpackage

// File: rtl/encoder_seq_if.sv
// rtl/encoder_seq_if.sv - pixel stream, image RAM port and tracer handoff bundle
// Purpose: groups the sequencer's bus signals.
// Ports (master = sequencer side):
//   pix_valid/pix_data in, pix_ready out   binary pixel load stream
//   mem_addr/mem_we/mem_wdata out, mem_rdata in   image RAM, 1-cycle read latency
//   trc_start/trc_x/trc_y out   seed handoff to tracer
//   trc_addr/trc_done in   tracer read address and completion
interface encoder_seq_if
  import encoder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int X_W    = $clog2(IMG_W_DEF),
  parameter int Y_W    = $clog2(IMG_H_DEF)
);

  logic              pix_valid;
  logic              pix_data;
  logic              pix_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_wdata;
  logic              mem_rdata;
  logic              trc_start;
  logic [X_W-1:0]    trc_x;
  logic [Y_W-1:0]    trc_y;
  logic [ADDR_W-1:0] trc_addr;
  logic              trc_done;

  modport master (
    input  pix_valid, pix_data, mem_rdata, trc_addr, trc_done,
    output pix_ready, mem_addr, mem_we, mem_wdata, trc_start, trc_x, trc_y
  );

  modport slave (
    output pix_valid, pix_data, mem_rdata, trc_addr, trc_done,
    input  pix_ready, mem_addr, mem_we, mem_wdata, trc_start, trc_x, trc_y
  );

endinterface

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster address counter with x/y split and terminal flag
// Purpose: row-major pixel address counter shared by image load and scan.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clr, inc     clear (wins over inc), increment (wraps to 0 after last)
//   count        full address; x = low X_W bits, y = remaining bits
//   last         count is the final pixel address
module raster_counter
  import encoder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int X_W    = $clog2(IMG_W_DEF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_W-1:0]     count,
  output logic [X_W-1:0]        x,
  output logic [ADDR_W-X_W-1:0] y,
  output logic                  last
);

  logic [ADDR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign x     = count_q[X_W-1:0];
  assign y     = count_q[ADDR_W-1:X_W];
  assign last  = &count_q;

endmodule

// File: rtl/encoder_seq.sv
// rtl/encoder_seq.sv - frame load / foreground scan / tracer seed sequencer
// Purpose: loads a binary frame into the image RAM, scans it row-major for the
//   first foreground pixel, hands that seed to the boundary tracer and lends it
//   the RAM port until the trace completes.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 frame start pulse (honoured only in IDLE)
//   bus (master)          pixel stream, RAM port, tracer handoff
//   busy, done            not idle; one-cycle completion pulse
//   found, err            foreground seen; trace watchdog expired
// Option: ENCODER_SEQ_TIMEOUT_EN enables the TRACE watchdog (TIMEOUT cycles);
//   without it TRACE waits indefinitely and err is 0.
module encoder_seq
  import encoder_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  encoder_seq_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err
);

  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);

  if (ADDR_W != X_W + Y_W) begin : g_bad_addr_w
    $error("ADDR_W must equal log2(IMG_W*IMG_H)");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t         state_q, state_d;
  logic           found_q, found_d;
  logic [X_W-1:0] trc_x_q, trc_x_d;
  logic [Y_W-1:0] trc_y_q, trc_y_d;
  // Set once the first scan read is in flight; from then on the counter holds
  // the address whose data is arriving while address+1 is being issued.
  logic           primed_q, primed_d;

  logic              cnt_clr, cnt_inc, cnt_last;
  logic [ADDR_W-1:0] cnt;
  logic [X_W-1:0]    cnt_x;
  logic [Y_W-1:0]    cnt_y;

`ifdef ENCODER_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic            err_q, err_d;
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  raster_counter #(.ADDR_W(ADDR_W), .X_W(X_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt),
    .x     (cnt_x),
    .y     (cnt_y),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      found_q  <= 1'b0;
      trc_x_q  <= '0;
      trc_y_q  <= '0;
      primed_q <= 1'b0;
`ifdef ENCODER_SEQ_TIMEOUT_EN
      err_q    <= 1'b0;
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      found_q  <= found_d;
      trc_x_q  <= trc_x_d;
      trc_y_q  <= trc_y_d;
      primed_q <= primed_d;
`ifdef ENCODER_SEQ_TIMEOUT_EN
      err_q    <= err_d;
      wd_q     <= wd_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    found_d  = found_q;
    trc_x_d  = trc_x_q;
    trc_y_d  = trc_y_q;
    primed_d = primed_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
`ifdef ENCODER_SEQ_TIMEOUT_EN
    err_d    = err_q;
    wd_d     = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_clr = 1'b1;
          found_d = 1'b0;
          trc_x_d = '0;
          trc_y_d = '0;
`ifdef ENCODER_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        primed_d = 1'b0;
        if (bus.pix_valid) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            state_d = ST_SCAN;
            cnt_clr = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (!primed_q) begin
          primed_d = 1'b1;
        end else if (bus.mem_rdata) begin
          found_d = 1'b1;
          trc_x_d = cnt_x;
          trc_y_d = cnt_y;
          state_d = ST_SEED;
        end else if (cnt_last) begin
          state_d = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_SEED: begin
        state_d = ST_TRACE;
      end
      ST_TRACE: begin
`ifdef ENCODER_SEQ_TIMEOUT_EN
        wd_d = wd_q + WD_W'(1);
        if (bus.trc_done) begin
          state_d = ST_DONE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          found_d = 1'b1;
          state_d = ST_DONE;
        end
`else
        if (bus.trc_done) begin
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  logic              pix_ready_c, mem_we_c, mem_wdata_c;
  logic [ADDR_W-1:0] mem_addr_c;

  always_comb begin
    pix_ready_c = (state_q == ST_LOAD);
    mem_we_c    = (state_q == ST_LOAD) && bus.pix_valid;
    mem_wdata_c = mem_we_c && bus.pix_data;
    mem_addr_c  = '0;
    case (state_q)
      ST_LOAD:  mem_addr_c = cnt;
      ST_SCAN:  mem_addr_c = primed_q ? cnt + ADDR_W'(1) : cnt;
      ST_TRACE: mem_addr_c = bus.trc_addr;
      default:  mem_addr_c = '0;
    endcase
  end

  assign bus.pix_ready = pix_ready_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.trc_start = (state_q == ST_SEED);
  assign bus.trc_x     = trc_x_q;
  assign bus.trc_y     = trc_y_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign found         = found_q;
`ifdef ENCODER_SEQ_TIMEOUT_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule
